reg_bank_write_arbiter: RTL and testbench

//  Shares one bank of DEPTH x WIDTH flip-flop registers between NREQ write requesters.
//  - Round-robin arbitration; one granted write per two clocks.
//  - Combinational read port.
//  - Sits between producer blocks and the storage flops. The flops use an

---
 rtl/reg_bank_write_arbiter_pkg.sv | 17 +
 rtl/reg_bank_write_arbiter_if.sv | 25 ++
 rtl/reg_bank_write_arbiter_bank_reg.sv | 21 ++
 rtl/reg_bank_write_arbiter.sv | 111 +++++++++++
 tb/tb_reg_bank_write_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM encodings and a
// constant-width helper.
package reg_bank_write_arbiter_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_COMMIT = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_if.sv
// Requester/read bus of the register-bank write arbiter. The producers and the
// reader sit on the master side; the arbiter is the slave.
interface reg_bank_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    wr_addr;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [AW-1:0]         rd_addr;
  logic [WIDTH-1:0]      rd_data;

  modport master (
    output req, wr_addr, wr_data, rd_addr,
    input  gnt, busy, rd_data
  );

  modport slave (
    input  req, wr_addr, wr_data, rd_addr,
    output gnt, busy, rd_data
  );
endinterface

// File: rtl/reg_bank_write_arbiter_bank_reg.sv
// One storage register of the bank: asynchronous active-low clear, load on i_we.
module reg_bank_write_arbiter_bank_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter in front of a DEPTH-entry register bank: one
// granted write per two clocks, combinational read port.
module reg_bank_write_arbiter
  import reg_bank_write_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                       clk,
  input  logic                       clear_n,
  reg_bank_write_arbiter_if.slave    bus
);

  localparam int PW = clog2(NREQ);

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [PW-1:0]    r_rr_ptr;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_data;

  logic             w_found;
  logic [NREQ-1:0]  w_gnt_nxt;
  logic [PW-1:0]    w_ptr_nxt;
  logic [AW-1:0]    w_sel_addr;
  logic [WIDTH-1:0] w_sel_data;
  logic [DEPTH-1:0] w_we;
  logic [WIDTH-1:0] w_q [DEPTH];
  logic [WIDTH-1:0] w_rd_data;

  // Search upward from r_rr_ptr with wrap; the first set request wins.
  always_comb begin
    int idx;
    idx        = 0;
    w_found    = 1'b0;
    w_gnt_nxt  = '0;
    w_ptr_nxt  = r_rr_ptr;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && bus.req[idx]) begin
        w_found        = 1'b1;
        w_gnt_nxt[idx] = 1'b1;
        w_ptr_nxt      = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
        w_sel_addr     = bus.wr_addr[idx*AW +: AW];
        w_sel_data     = bus.wr_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state  <= ST_COMMIT;
            r_gnt    <= w_gnt_nxt;
            r_rr_ptr <= w_ptr_nxt;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // Address/data are sampled only at the grant edge; later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_found) begin
      r_addr <= w_sel_addr;
      r_data <= w_sel_data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_bank
    assign w_we[g] = (r_state == ST_COMMIT) && (r_addr == AW'(g));

    reg_bank_write_arbiter_bank_reg #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk     (clk),
      .clear_n (clear_n),
      .i_we    (w_we[g]),
      .i_d     (r_data),
      .o_q     (w_q[g])
    );
  end

  // Addresses past DEPTH match no entry and read as zero.
  always_comb begin
    w_rd_data = '0;
    for (int d = 0; d < DEPTH; d++) begin
      if (bus.rd_addr == AW'(d)) w_rd_data = w_q[d];
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = (r_state == ST_COMMIT);
  assign bus.rd_data = w_rd_data;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Scenario bench for reg_bank_write_arbiter: directed cases plus randomized
// traffic scored against a behavioural bank/round-robin model.
module tb_reg_bank_write_arbiter;

  logic clk;
  logic clear_n;
  int   n_checks;
  int   n_fail;

  logic [7:0] m_bank [4];
  int         m_rr;

  reg_bank_write_arbiter_if #(.NREQ(4), .WIDTH(8), .AW(2)) bus  ();
  reg_bank_write_arbiter_if #(.NREQ(4), .WIDTH(8), .AW(2)) bus3 ();

  reg_bank_write_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  reg_bank_write_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(3), .AW(2)) dut3 (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
    bus.wr_addr[i*2 +: 2] = a;
    bus.wr_data[i*8 +: 8] = d;
  endtask

  function automatic int pick(input logic [3:0] r, input int rr);
    for (int k = 0; k < 4; k++) begin
      if (r[(rr + k) % 4]) return (rr + k) % 4;
    end
    return -1;
  endfunction

  task automatic test_reset();
    #3;
    n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 2'(a); #1;
      n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd[%0d] got=%h exp=00", a, bus.rd_data); end
    end
    @(negedge clk); clear_n = 1'b1;
    set_req(1, 2'd1, 8'h3C); bus.req = 4'b0010;
    tick(); bus.req = 4'b0000;
    tick(); bus.rd_addr = 2'd1; #1;
    n_checks++; if (bus.rd_data !== 8'h3C) begin n_fail++; $display("FAIL pre_reset_write got=%h exp=3c", bus.rd_data); end
    set_req(0, 2'd0, 8'h77); bus.req = 4'b0001;
    tick();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_commit_busy got=%b exp=1", bus.busy); end
    #2 clear_n = 1'b0; #1;
    n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL async_clear_gnt got=%b exp=0000", bus.gnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_clear_busy got=%b exp=0", bus.busy); end
    bus.req = 4'b0000;
    @(posedge clk); @(negedge clk); clear_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 2'(a); #1;
      n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL abort_rd[%0d] got=%h exp=00", a, bus.rd_data); end
      m_bank[a] = 8'h00;
    end
    m_rr = 0;
  endtask

  task automatic test_fairness();
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'h10 + 8'(i));
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (bus.gnt !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL fair_gnt[%0d] got=%b exp=%b", k, bus.gnt, 4'(1 << (k % 4))); end
      tick();
      n_checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL fair_gap[%0d] gnt=%b busy=%b exp=0000/0", k, bus.gnt, bus.busy); end
    end
    bus.req = 4'b0000;
    for (int a = 0; a < 4; a++) begin
      m_bank[a] = 8'h10 + 8'(a);
      bus.rd_addr = 2'(a); #1;
      n_checks++; if (bus.rd_data !== m_bank[a]) begin n_fail++; $display("FAIL fair_bank[%0d] got=%h exp=%h", a, bus.rd_data, m_bank[a]); end
    end
    m_rr = 1;
  endtask

  task automatic test_single_write();
    set_req(0, 2'd2, 8'hA5); bus.req = 4'b0001; bus.rd_addr = 2'd2;
    tick();
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt got=%b exp=0001", bus.gnt); end
    n_checks++; if (bus.rd_data !== m_bank[2]) begin n_fail++; $display("FAIL single_no_bypass got=%h exp=%h", bus.rd_data, m_bank[2]); end
    bus.req = 4'b0000;
    tick();
    n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_drop got=%b exp=0000", bus.gnt); end
    n_checks++; if (bus.rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_rd got=%h exp=a5", bus.rd_data); end
    m_bank[2] = 8'hA5;
    m_rr = 1;
  endtask

  task automatic test_wrap();
    set_req(2, 2'd2, 8'h22); bus.req = 4'b0100;
    tick();
    n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL wrap_setup got=%b exp=0100", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    set_req(3, 2'd3, 8'h33); set_req(0, 2'd0, 8'h99); bus.req = 4'b1001;
    tick();
    n_checks++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_first got=%b exp=1000", bus.gnt); end
    tick(); tick();
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_second got=%b exp=0001", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    m_bank[2] = 8'h22; m_bank[3] = 8'h33; m_bank[0] = 8'h99; m_rr = 1;
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 2'(a); #1;
      n_checks++; if (bus.rd_data !== m_bank[a]) begin n_fail++; $display("FAIL wrap_bank[%0d] got=%h exp=%h", a, bus.rd_data, m_bank[a]); end
    end
  endtask

  task automatic test_hold_off();
    set_req(0, 2'd1, 8'h11); bus.req = 4'b0001; bus.rd_addr = 2'd1;
    tick();
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL hold_gnt got=%b exp=0001", bus.gnt); end
    set_req(0, 2'd1, 8'h22); bus.req = 4'b0000;
    tick();
    n_checks++; if (bus.rd_data !== 8'h11) begin n_fail++; $display("FAIL hold_stored got=%h exp=11", bus.rd_data); end
    tick();
    n_checks++; if (bus.rd_data !== 8'h11 || bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL hold_idle rd=%h gnt=%b exp=11/0000", bus.rd_data, bus.gnt); end
    bus.req = 4'b0001;
    tick();
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL hold_regrant got=%b exp=0001", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    n_checks++; if (bus.rd_data !== 8'h22) begin n_fail++; $display("FAIL hold_new got=%h exp=22", bus.rd_data); end
    m_bank[1] = 8'h22; m_rr = 1;
  endtask

  task automatic test_range();
    logic [7:0] exp3 [4];
    exp3[0] = 8'h00; exp3[1] = 8'h00; exp3[2] = 8'h5C; exp3[3] = 8'h00;
    bus3.wr_addr = 8'b00_00_10_00; bus3.wr_data = 32'h0000_5C00; bus3.req = 4'b0010;
    tick();
    n_checks++; if (bus3.gnt !== 4'b0010) begin n_fail++; $display("FAIL range_setup got=%b exp=0010", bus3.gnt); end
    bus3.req = 4'b0000;
    tick();
    bus3.wr_addr = 8'b00_00_00_11; bus3.wr_data = 32'h0000_00FF; bus3.req = 4'b0001;
    tick();
    n_checks++; if (bus3.gnt !== 4'b0001 || bus3.busy !== 1'b1) begin n_fail++; $display("FAIL range_gnt gnt=%b busy=%b exp=0001/1", bus3.gnt, bus3.busy); end
    bus3.req = 4'b0000;
    tick();
    n_checks++; if (bus3.gnt !== 4'b0000) begin n_fail++; $display("FAIL range_gnt_drop got=%b exp=0000", bus3.gnt); end
    for (int a = 0; a < 4; a++) begin
      bus3.rd_addr = 2'(a); #1;
      n_checks++; if (bus3.rd_data !== exp3[a]) begin n_fail++; $display("FAIL range_rd[%0d] got=%h exp=%h", a, bus3.rd_data, exp3[a]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 120; it++) begin
      logic [3:0] rq;
      logic [1:0] ca;
      logic [7:0] cd;
      int         w;
      rq = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      bus.wr_addr = 8'($urandom);
      bus.wr_data = 32'($urandom);
      bus.rd_addr = 2'($urandom);
      bus.req     = rq;
      w = pick(rq, m_rr);
      #1;
      n_checks++; if (bus.rd_data !== m_bank[bus.rd_addr]) begin n_fail++; $display("FAIL rand_rd[%0d] addr=%0d got=%h exp=%h", it, bus.rd_addr, bus.rd_data, m_bank[bus.rd_addr]); end
      tick();
      if (w < 0) begin
        n_checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rand_idle[%0d] gnt=%b busy=%b exp=0000/0", it, bus.gnt, bus.busy); end
      end else begin
        ca = bus.wr_addr[w*2 +: 2];
        cd = bus.wr_data[w*8 +: 8];
        n_checks++; if (bus.gnt !== 4'(1 << w) || bus.busy !== 1'b1) begin n_fail++; $display("FAIL rand_gnt[%0d] gnt=%b busy=%b exp=%b/1", it, bus.gnt, bus.busy, 4'(1 << w)); end
        m_rr = (w + 1) % 4;
        bus.wr_data = 32'($urandom);
        bus.wr_addr = 8'($urandom);
        bus.req     = 4'($urandom);
        tick();
        m_bank[ca] = cd;
        bus.rd_addr = ca; #1;
        n_checks++; if (bus.gnt !== 4'b0000 || bus.rd_data !== cd) begin n_fail++; $display("FAIL rand_commit[%0d] gnt=%b rd=%h exp=0000/%h", it, bus.gnt, bus.rd_data, cd); end
      end
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_rr     = 0;
    clear_n  = 1'b0;
    bus.req = '0;  bus.wr_addr = '0;  bus.wr_data = '0;  bus.rd_addr = '0;
    bus3.req = '0; bus3.wr_addr = '0; bus3.wr_data = '0; bus3.rd_addr = '0;
    test_reset();
    test_fairness();
    test_single_write();
    test_wrap();
    test_hold_off();
    test_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
